// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage pipeline.
//   - Merges per-stage stall requests into the 6-bit stall vector used by
//     pc_reg and the if_id/id_ex/ex_mem/mem_wb registers.
//   - Sequences exception redirects. It flushes the younger stages, waits for
//     any in-flight fetch bus transaction to finish (bounded by a timeout),
//     and then issues one redirect PC.
//   - Keeps a saturating count of the cycles in which the PC was held.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage hold requests (priority mem > ex > id > if)
//   exc_valid       exception/eret committed in MEM this cycle
//   exc_target      handler/return PC for exc_valid
//   if_bus_busy     IF bus transaction outstanding
//   stall[5:0]      [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
//   flush           clear all pipeline registers to bubble
//   new_pc          redirect target
//   new_pc_valid    pc_reg loads new_pc this cycle
//   timeout_err     sticky flag: fetch drain wait timed out
//   stall_cycles    saturating count of cycles with stall[0]=1
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 32,
   parameter logic [31:0] PC_RESET       = 32'hBFC00000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic             exc_valid,
   input  logic [31:0]      exc_target,
   input  logic             if_bus_busy,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             new_pc_valid,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_IF  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t           state_q,        state_d;
   logic [31:0]      new_pc_q,       new_pc_d;
   logic [TO_W-1:0]  to_cnt_q,       to_cnt_d;
   logic             timeout_err_q,  timeout_err_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values computed before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         new_pc_q       <= PC_RESET;
         to_cnt_q       <= '0;
         timeout_err_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         new_pc_q       <= new_pc_d;
         to_cnt_q       <= to_cnt_d;
         timeout_err_q  <= timeout_err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      new_pc_d      = new_pc_q;
      to_cnt_d      = to_cnt_q;
      timeout_err_d = timeout_err_q;
      stall         = 6'b000000;
      flush         = 1'b0;
      new_pc_valid  = 1'b0;
      new_pc        = new_pc_q;

      unique case (state_q)
         RUN: begin
            if (exc_valid) begin
               // Exception overrides any stall request: the whole pipe is
               // flushed, so there is nothing left worth holding.
               flush    = 1'b1;
               new_pc_d = exc_target;
               if (!if_bus_busy) begin
                  new_pc_valid = 1'b1;
                  new_pc       = exc_target;
               end else begin
                  state_d  = WAIT_IF;
                  to_cnt_d = '0;
               end
            end else if (stallreq_mem) begin
               stall = 6'b011111;
            end else if (stallreq_ex) begin
               stall = 6'b001111;
            end else if (stallreq_id) begin
               stall = 6'b000111;
            end else if (stallreq_if) begin
               stall = 6'b000011;
            end
         end

         WAIT_IF: begin
            // Hold PC and IF so the outstanding fetch cannot be re-issued.
            stall    = 6'b000011;
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (!if_bus_busy) begin
               state_d = REDIRECT;
            end else if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
               state_d       = REDIRECT;
               timeout_err_d = 1'b1;
            end
         end

         REDIRECT: begin
            // Flush again to discard whatever the drained fetch returned.
            flush        = 1'b1;
            new_pc_valid = 1'b1;
            state_d      = RUN;
         end

         default: state_d = RUN;
      endcase

      // Combinational outputs read as idle while reset is asserted.
      if (rst) begin
         stall        = 6'b000000;
         flush        = 1'b0;
         new_pc_valid = 1'b0;
         new_pc       = new_pc_q;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall[0] && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   assign timeout_err  = timeout_err_q;
   assign stall_cycles = stall_cycles_q;

endmodule
